// File: rtl/clone_probe_if.sv
// PPU-side probe signals and verdict/status outputs of clone_probe.
interface clone_probe_if;
    logic       ppu_rd_in;
    logic       ppu_a13;
    logic       ppu_not_a13;
    logic       init_active;
    logic       detect_done;
    logic       new_dendy;
    logic       timeout;
    logic [7:0] mismatch_count;

    // Host side: drives the PPU bus view, observes the verdict.
    modport master (
        output ppu_rd_in,
        output ppu_a13,
        output ppu_not_a13,
        input  init_active,
        input  detect_done,
        input  new_dendy,
        input  timeout,
        input  mismatch_count
    );

    // Probe side: samples the PPU bus view, reports the verdict.
    modport slave (
        input  ppu_rd_in,
        input  ppu_a13,
        input  ppu_not_a13,
        output init_active,
        output detect_done,
        output new_dendy,
        output timeout,
        output mismatch_count
    );
endinterface

// File: rtl/clone_probe.sv
// Power-on console probe: holds the CIRAM grounding window after reset, then
// samples PPU reads to decide whether the host drives /A13 as the complement
// of A13. A "new" famiclone (new_dendy=1) does not.
module clone_probe #(
    parameter int unsigned INIT_CYCLES        = 15,
    parameter int unsigned LOW_SAMPLES        = 2,
    parameter int unsigned HIGH_SAMPLES       = 2,
    parameter int unsigned MISMATCH_THRESHOLD = 1,
    parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
    input  logic        m2,
    input  logic        reset,
    clone_probe_if.slave bus
);

    localparam int unsigned IW = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES);
    localparam logic [7:0]    LOW_MAX   = 8'(LOW_SAMPLES);
    localparam logic [7:0]    HIGH_MAX  = 8'(HIGH_SAMPLES);
    localparam logic [7:0]    MM_THR    = 8'(MISMATCH_THRESHOLD);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam bit            TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam bit            SKIP_INIT = (INIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_PROBE,
        ST_DONE
    } state_t;

    // Synchroniser stages
    logic rd_s1, rd_s2, rd_prev;
    logic a13_s1, a13_s2;
    logic na13_s1, na13_s2;

    logic read_event;
    logic sample_mismatch;

    // FSM state and counters
    state_t        state, state_nx;
    logic [IW-1:0] init_cnt, init_cnt_nx;
    logic [7:0]    low_cnt, low_nx, low_upd;
    logic [7:0]    high_cnt, high_nx, high_upd;
    logic [7:0]    mm_cnt, mm_nx, mm_upd;
    logic [TW-1:0] to_cnt, to_nx;
    logic          done_r, done_nx;
    logic          nd_r, nd_nx;
    logic          to_r, to_flag_nx;

    // Bring the asynchronous PPU signals into the m2 domain; rd idles high.
    always_ff @(posedge m2) begin
        if (reset) begin
            rd_s1   <= 1'b1;
            rd_s2   <= 1'b1;
            rd_prev <= 1'b1;
            a13_s1  <= 1'b0;
            a13_s2  <= 1'b0;
            na13_s1 <= 1'b0;
            na13_s2 <= 1'b0;
        end else begin
            rd_s1   <= bus.ppu_rd_in;
            rd_s2   <= rd_s1;
            rd_prev <= rd_s2;
            a13_s1  <= bus.ppu_a13;
            a13_s2  <= a13_s1;
            na13_s1 <= bus.ppu_not_a13;
            na13_s2 <= na13_s1;
        end
    end

    assign read_event      = ~rd_s2 & rd_prev;
    assign sample_mismatch = (a13_s2 == na13_s2);

    // State register, counters and registered verdict outputs.
    always_ff @(posedge m2) begin
        if (reset) begin
            if (SKIP_INIT) begin
                state <= ST_PROBE;
            end else begin
                state <= ST_INIT;
            end
            init_cnt <= INIT_LOAD;
            low_cnt  <= '0;
            high_cnt <= '0;
            mm_cnt   <= '0;
            to_cnt   <= '0;
            done_r   <= 1'b0;
            nd_r     <= 1'b0;
            to_r     <= 1'b0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
            low_cnt  <= low_nx;
            high_cnt <= high_nx;
            mm_cnt   <= mm_nx;
            to_cnt   <= to_nx;
            done_r   <= done_nx;
            nd_r     <= nd_nx;
            to_r     <= to_flag_nx;
        end
    end

    // Next-state logic: grounding countdown, sample accumulation, verdict.
    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        low_nx      = low_cnt;
        high_nx     = high_cnt;
        mm_nx       = mm_cnt;
        to_nx       = to_cnt;
        done_nx     = done_r;
        nd_nx       = nd_r;
        to_flag_nx  = to_r;

        // Candidate counter updates for this cycle's read event; only
        // committed while probing.
        low_upd  = low_cnt;
        high_upd = high_cnt;
        mm_upd   = mm_cnt;
        if (read_event && !a13_s2 && (low_cnt != LOW_MAX)) begin
            low_upd = low_cnt + 8'd1;
        end
        if (read_event && a13_s2 && (high_cnt != HIGH_MAX)) begin
            high_upd = high_cnt + 8'd1;
        end
        if (read_event && sample_mismatch && (mm_cnt != 8'hFF)) begin
            mm_upd = mm_cnt + 8'd1;
        end

        case (state)
            ST_INIT: begin
                if (init_cnt <= IW'(1)) begin
                    state_nx = ST_PROBE;
                end
                if (init_cnt != '0) begin
                    init_cnt_nx = init_cnt - IW'(1);
                end
            end
            ST_PROBE: begin
                low_nx  = low_upd;
                high_nx = high_upd;
                mm_nx   = mm_upd;
                if (TO_EN && (to_cnt != TO_LAST)) begin
                    to_nx = to_cnt + TW'(1);
                end
                // Verdict priority: mismatch, then sample completion, then timeout.
                if (mm_upd >= MM_THR) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                    nd_nx    = 1'b1;
                end else if ((low_upd == LOW_MAX) && (high_upd == HIGH_MAX)) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    state_nx   = ST_DONE;
                    done_nx    = 1'b1;
                    to_flag_nx = 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_DONE;
            end
            default: begin
                state_nx = ST_INIT;
            end
        endcase
    end

    assign bus.init_active    = (state == ST_INIT);
    assign bus.detect_done    = done_r;
    assign bus.new_dendy      = nd_r;
    assign bus.timeout        = to_r;
    assign bus.mismatch_count = mm_cnt;

endmodule

// File: tb/tb_clone_probe.sv
// Scoreboard bench for clone_probe: four parameterisations share one PPU
// stimulus; expected verdicts are queued when the deciding read is issued and
// a monitor pops them when a watched DUT raises detect_done.
module tb_clone_probe;

    logic m2    = 1'b0;
    logic reset = 1'b1;
    logic rd    = 1'b1;
    logic a13   = 1'b0;
    logic na    = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    clone_probe_if ifa ();
    clone_probe_if ifb ();
    clone_probe_if ifc ();
    clone_probe_if ifd ();

    assign ifa.ppu_rd_in = rd;  assign ifa.ppu_a13 = a13;  assign ifa.ppu_not_a13 = na;
    assign ifb.ppu_rd_in = rd;  assign ifb.ppu_a13 = a13;  assign ifb.ppu_not_a13 = na;
    assign ifc.ppu_rd_in = rd;  assign ifc.ppu_a13 = a13;  assign ifc.ppu_not_a13 = na;
    assign ifd.ppu_rd_in = rd;  assign ifd.ppu_a13 = a13;  assign ifd.ppu_not_a13 = na;

    clone_probe #(.INIT_CYCLES(15)) dut_a (.m2(m2), .reset(reset), .bus(ifa));
    clone_probe #(.INIT_CYCLES(4), .MISMATCH_THRESHOLD(3)) dut_b (.m2(m2), .reset(reset), .bus(ifb));
    clone_probe #(.INIT_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_c (.m2(m2), .reset(reset), .bus(ifc));
    clone_probe #(.INIT_CYCLES(3), .TIMEOUT_CYCLES(0)) dut_d (.m2(m2), .reset(reset), .bus(ifd));

    logic [3:0] done_v, nd_v, to_v, ia_v;
    logic [7:0] mc_v [4];

    assign done_v = {ifd.detect_done, ifc.detect_done, ifb.detect_done, ifa.detect_done};
    assign nd_v   = {ifd.new_dendy, ifc.new_dendy, ifb.new_dendy, ifa.new_dendy};
    assign to_v   = {ifd.timeout, ifc.timeout, ifb.timeout, ifa.timeout};
    assign ia_v   = {ifd.init_active, ifc.init_active, ifb.init_active, ifa.init_active};
    assign mc_v[0] = ifa.mismatch_count;
    assign mc_v[1] = ifb.mismatch_count;
    assign mc_v[2] = ifc.mismatch_count;
    assign mc_v[3] = ifd.mismatch_count;

    typedef struct {
        int         id;
        int         cyc;
        logic       nd;
        logic       to;
        logic [7:0] mc;
    } exp_t;

    exp_t       sbq [$];
    exp_t       mon_e;
    logic [3:0] watch     = 4'b0000;
    logic [3:0] done_prev = 4'b0000;

    always #5 m2 = ~m2;

    always @(posedge m2) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising detect_done on a watched DUT consumes one expectation.
    always @(negedge m2) begin
        for (int i = 0; i < 4; i++) begin
            if (watch[i] && done_v[i] && !done_prev[i]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: dut=%0d at cyc=%0d, no verdict expected", i, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("dut_id", i, mon_e.id);
                    chk("done_cycle", cyc, mon_e.cyc);
                    chk("new_dendy", nd_v[i], mon_e.nd);
                    chk("timeout", to_v[i], mon_e.to);
                    chk("mismatch_count", mc_v[i], mon_e.mc);
                end
            end
        end
        done_prev = done_v;
    end

    task automatic do_reset();
        @(negedge m2);
        reset = 1'b1;
        rd    = 1'b1;
        repeat (3) @(negedge m2);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge m2);
    endtask

    // One PPU read; with push set, the verdict it should produce is queued
    // for three edges after the /RD fall.
    task automatic ppu_read(input logic a, input logic n, input bit push, input int id,
                            input logic e_nd, input logic e_to, input logic [7:0] e_mc);
        exp_t e;
        @(negedge m2);
        a13 = a;
        na  = n;
        rd  = 1'b0;
        if (push) begin
            e.id  = id;
            e.cyc = cyc + 3;
            e.nd  = e_nd;
            e.to  = e_to;
            e.mc  = e_mc;
            sbq.push_back(e);
        end
        repeat (2) @(negedge m2);
        rd = 1'b1;
        repeat (2) @(negedge m2);
    endtask

    task automatic rd_plain(input logic a, input logic n);
        ppu_read(a, n, 1'b0, 0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_init_active"}, ifa.init_active, 1'b1);
        chk({tag, "_detect_done"}, ifa.detect_done, 1'b0);
        chk({tag, "_new_dendy"}, ifa.new_dendy, 1'b0);
        chk({tag, "_timeout"}, ifa.timeout, 1'b0);
        chk({tag, "_mismatch_count"}, ifa.mismatch_count, 8'd0);
    endtask

    initial begin
        int na_cnt, nb_cnt, nd_cnt, c0;

        // Reset values and grounding window length.
        do_reset();
        chk_reset_a("rst");
        chk("rst_init_active_c", ifc.init_active, 1'b0);
        na_cnt = 0; nb_cnt = 0; nd_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (ia_v[0]) na_cnt++;
            if (ia_v[1]) nb_cnt++;
            if (ia_v[3]) nd_cnt++;
            @(negedge m2);
        end
        chk("init_len_a", na_cnt, 15);
        chk("init_len_b", nb_cnt, 4);
        chk("init_len_d", nd_cnt, 3);
        chk("init_end_a", ifa.init_active, 1'b0);
        chk("idle_done_a", ifa.detect_done, 1'b0);

        // Clean host: two low and two high complementary reads.
        watch = 4'b0001;
        rd_plain(1'b0, 1'b1);
        rd_plain(1'b0, 1'b1);
        rd_plain(1'b1, 1'b0);
        chk("early_done_a", ifa.detect_done, 1'b0);
        ppu_read(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'd0);
        idle(6);
        chk("sb_drain_clean", sbq.size(), 0);

        // Threshold 3 with /A13 stuck high: two mismatches are tolerated.
        do_reset();
        watch = 4'b0010;
        idle(10);
        rd_plain(1'b1, 1'b1);
        rd_plain(1'b1, 1'b1);
        rd_plain(1'b0, 1'b1);
        ppu_read(1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 8'd2);
        rd_plain(1'b0, 1'b1);
        rd_plain(1'b0, 1'b1);
        chk("frozen_mc_b2", ifb.mismatch_count, 8'd2);
        chk("sb_drain_thr2", sbq.size(), 0);

        // Third mismatch first: new famiclone verdict, later reads ignored.
        do_reset();
        idle(10);
        rd_plain(1'b1, 1'b1);
        rd_plain(1'b1, 1'b1);
        ppu_read(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 8'd3);
        rd_plain(1'b0, 1'b1);
        rd_plain(1'b0, 1'b1);
        rd_plain(1'b1, 1'b0);
        rd_plain(1'b1, 1'b0);
        chk("frozen_mc_b3", ifb.mismatch_count, 8'd3);
        chk("frozen_nd_b3", ifb.new_dendy, 1'b1);
        chk("sb_drain_thr3", sbq.size(), 0);

        // Final read both completes sampling and mismatches: mismatch wins.
        do_reset();
        watch = 4'b0001;
        idle(20);
        rd_plain(1'b0, 1'b1);
        rd_plain(1'b1, 1'b0);
        rd_plain(1'b0, 1'b1);
        ppu_read(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'd1);
        idle(4);
        chk("sb_drain_prio", sbq.size(), 0);

        // Timeout of 100 PROBE cycles (no grounding window on this DUT).
        do_reset();
        watch = 4'b0100;
        c0 = cyc;
        sbq.push_back('{id: 2, cyc: c0 + 100, nd: 1'b0, to: 1'b1, mc: 8'd0});
        idle(110);
        chk("sb_drain_timeout", sbq.size(), 0);

        // Timeout disabled: still undecided after 10000 cycles.
        do_reset();
        watch = 4'b1000;
        idle(10000);
        chk("no_timeout_done_d", ifd.detect_done, 1'b0);
        chk("no_timeout_flag_d", ifd.timeout, 1'b0);

        // Reset mid-PROBE discards the earlier sample.
        do_reset();
        watch = 4'b0001;
        idle(20);
        rd_plain(1'b0, 1'b1);
        idle(3);
        do_reset();
        chk_reset_a("rerst");
        na_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (ia_v[0]) na_cnt++;
            @(negedge m2);
        end
        chk("init_len_a_rerst", na_cnt, 15);
        rd_plain(1'b1, 1'b0);
        rd_plain(1'b1, 1'b0);
        rd_plain(1'b0, 1'b1);
        idle(3);
        chk("discard_done_a", ifa.detect_done, 1'b0);
        ppu_read(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0);
        idle(4);

        chk("sb_drain_final", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
